b_pwr_monitor_filt: RTL and testbench

B_PWR_MONITOR_FILT -- requirements
Module: b_pwr_monitor_filt

---
 rtl/b_pwr_monitor_filt.sv | 164 ++++++++++++++++
 tb/tb_b_pwr_monitor_filt.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/b_pwr_monitor_filt.sv
// rtl/b_pwr_monitor_filt.sv - power-good monitor with per-channel glitch filter and sticky warn/fault flags
// Optional feature macro: B_PWR_MONITOR_FILT_FAULT_CNT_EN (saturating fault event counter)
module b_pwr_monitor_filt #(
  parameter int NUM_CONVERTERS = 1,
  parameter int PGOOD_MODE     = 0,
  parameter int FILTER_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        warn,
  output logic        fault,
  output logic        eoc,
  output logic [31:0] pgood_bus,
  output logic [7:0]  fault_cnt
);

  // Count value on which a persistent mismatch is finally accepted.
  localparam logic [3:0] CNT_LAST = 4'(FILTER_DEPTH - 1);

  logic [NUM_CONVERTERS-1:0]      raw;
  logic [NUM_CONVERTERS-1:0]      filt;
  logic [NUM_CONVERTERS-1:0]      filt_nxt;
  logic [NUM_CONVERTERS-1:0][3:0] cnt;
  logic [NUM_CONVERTERS-1:0][3:0] cnt_nxt;
  logic [31:0]                    pgood_nxt;
  logic                           eoc_tog;
  logic                           ctrl_wr;
  logic                           clr_wr;
  logic                           filt_fall;
  logic                           warn_nxt;
  logic                           fault_nxt;
  logic                           unused_data;

  assign ctrl_wr = wr_en && (wr_addr == 3'd4);
  assign clr_wr  = wr_en && (wr_addr == 3'd5);

  // Data bits that a given channel count or build may never look at.
  assign unused_data = ^wr_data;

  // Bank writes: each raw bit belongs to bank i/8; bits beyond the channel count do not exist.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      raw <= '0;
    end else begin
      for (int i = 0; i < NUM_CONVERTERS; i++) begin
        if (wr_en && (wr_addr == 3'(i / 8))) begin
          raw[i] <= wr_data[i % 8];
        end
      end
    end
  end

  // Glitch filter next state: a mismatch must persist FILTER_DEPTH clocks before filt follows raw.
  always_comb begin
    filt_nxt = filt;
    cnt_nxt  = cnt;
    for (int i = 0; i < NUM_CONVERTERS; i++) begin
      if (raw[i] == filt[i]) begin
        cnt_nxt[i] = 4'd0;
      end else if (cnt[i] == CNT_LAST) begin
        filt_nxt[i] = raw[i];
        cnt_nxt[i]  = 4'd0;
      end else begin
        cnt_nxt[i] = cnt[i] + 4'd1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      cnt  <= '0;
    end else begin
      filt <= filt_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // pgood is built from the next filter value so it moves on the same edge as filt.
  always_comb begin
    pgood_nxt = '0;
    if (PGOOD_MODE == 0) begin
      pgood_nxt[0] = &filt_nxt;
    end else begin
      for (int i = 0; i < NUM_CONVERTERS; i++) begin
        pgood_nxt[i] = filt_nxt[i];
      end
    end
  end

  // Registered power-good output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pgood_bus <= '0;
    end else begin
      pgood_bus <= pgood_nxt;
    end
  end

  // Brown-out: any filtered channel dropping from good to bad.
  assign filt_fall = |(filt & ~filt_nxt);

  // Sticky flag next state; a set in the same cycle as a clear takes priority.
  always_comb begin
    warn_nxt = warn;
    if (ctrl_wr && wr_data[0]) begin
      warn_nxt = 1'b1;
    end else if (clr_wr && wr_data[0]) begin
      warn_nxt = 1'b0;
    end
    fault_nxt = fault;
    if ((ctrl_wr && wr_data[1]) || filt_fall) begin
      fault_nxt = 1'b1;
    end else if (clr_wr && wr_data[1]) begin
      fault_nxt = 1'b0;
    end
  end

  // Flag, toggle and end-of-conversion pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      warn    <= 1'b0;
      fault   <= 1'b0;
      eoc_tog <= 1'b0;
      eoc     <= 1'b0;
    end else begin
      warn  <= warn_nxt;
      fault <= fault_nxt;
      if (ctrl_wr) begin
        eoc_tog <= wr_data[2];
        eoc     <= wr_data[2] ^ eoc_tog;
      end else begin
        eoc     <= 1'b0;
      end
    end
  end

`ifdef B_PWR_MONITOR_FILT_FAULT_CNT_EN
  logic [7:0] fault_cnt_q;
  logic       fault_rise;

  assign fault_rise = !fault && fault_nxt;

  // Saturating count of fault rising transitions; clear bit7 of a clear write zeroes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fault_cnt_q <= 8'h00;
    end else if (clr_wr && wr_data[7]) begin
      fault_cnt_q <= 8'h00;
    end else if (fault_rise && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_q <= fault_cnt_q + 8'h01;
    end
  end

  assign fault_cnt = fault_cnt_q;
`else
  assign fault_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_b_pwr_monitor_filt.sv
// tb/tb_b_pwr_monitor_filt.sv - directed table-driven bench for b_pwr_monitor_filt
module tb_b_pwr_monitor_filt;

  typedef struct {
    logic [2:0]  addr;
    logic [7:0]  data;
    int          idle;
    logic [31:0] pgood;
    logic        warn;
    logic        fault;
    logic        eoc;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic        wr_en_a, wr_en_b;
  logic [2:0]  wr_addr_a, wr_addr_b;
  logic [7:0]  wr_data_a, wr_data_b;
  logic        warn_a, fault_a, eoc_a;
  logic        warn_b, fault_b, eoc_b;
  logic [31:0] pgood_a, pgood_b;
  logic [7:0]  fcnt_a, fcnt_b;

  int total = 0;
  int bad   = 0;
  int fcnt_exp_three;
  int fcnt_exp_sat;
  vec_t tbl[$];

  b_pwr_monitor_filt #(.NUM_CONVERTERS(8), .PGOOD_MODE(1), .FILTER_DEPTH(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .warn(warn_a), .fault(fault_a), .eoc(eoc_a), .pgood_bus(pgood_a), .fault_cnt(fcnt_a)
  );

  b_pwr_monitor_filt #(.NUM_CONVERTERS(12), .PGOOD_MODE(0), .FILTER_DEPTH(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .warn(warn_b), .fault(fault_b), .eoc(eoc_b), .pgood_bus(pgood_b), .fault_cnt(fcnt_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next rising edge, returns at the following negedge.
  task automatic wr(input bit sel, input logic [2:0] a, input logic [7:0] d);
    if (!sel) begin
      wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
    end else begin
      wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d;
    end
    @(negedge clock);
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic add(input logic [2:0] a, input logic [7:0] d, input int n,
                     input logic [31:0] pg, input logic w, input logic f, input logic e);
    vec_t v;
    v.addr = a; v.data = d; v.idle = n; v.pgood = pg; v.warn = w; v.fault = f; v.eoc = e;
    tbl.push_back(v);
  endtask

  initial begin
`ifdef B_PWR_MONITOR_FILT_FAULT_CNT_EN
    fcnt_exp_three = 3;
    fcnt_exp_sat   = 255;
`else
    fcnt_exp_three = 0;
    fcnt_exp_sat   = 0;
`endif
    // addr, data, idle clocks after write, pgood, warn, fault, eoc
    add(3'd0, 8'hFF, 3, 32'h00, 0, 0, 0);
    add(3'd7, 8'hFF, 0, 32'hFF, 0, 0, 0);
    add(3'd6, 8'h00, 0, 32'hFF, 0, 0, 0);
    add(3'd1, 8'hFF, 5, 32'hFF, 0, 0, 0);
    add(3'd0, 8'hF7, 2, 32'hFF, 0, 0, 0);
    add(3'd0, 8'hFF, 5, 32'hFF, 0, 0, 0);
    add(3'd4, 8'h04, 0, 32'hFF, 0, 0, 1);
    add(3'd4, 8'h04, 0, 32'hFF, 0, 0, 0);
    add(3'd4, 8'h00, 0, 32'hFF, 0, 0, 1);
    add(3'd5, 8'h00, 0, 32'hFF, 0, 0, 0);
    add(3'd4, 8'h03, 0, 32'hFF, 1, 1, 0);
    add(3'd5, 8'h01, 0, 32'hFF, 0, 1, 0);
    add(3'd5, 8'h02, 0, 32'hFF, 0, 0, 0);
    add(3'd4, 8'h03, 0, 32'hFF, 1, 1, 0);
    add(3'd0, 8'hF7, 3, 32'hFF, 1, 1, 0);
    add(3'd5, 8'h03, 0, 32'hF7, 0, 1, 0);
    add(3'd0, 8'hFF, 4, 32'hFF, 0, 1, 0);
    add(3'd5, 8'h02, 0, 32'hFF, 0, 0, 0);
    add(3'd0, 8'hF7, 3, 32'hFF, 0, 0, 0);
    add(3'd0, 8'hFF, 0, 32'hF7, 0, 1, 0);
    add(3'd6, 8'h00, 3, 32'hFF, 0, 1, 0);

    reset_n = 1'b0;
    wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    idle(3);
    chk("reset pgood_a", pgood_a, 32'h0);
    chk("reset flags_a", {29'd0, warn_a, fault_a, eoc_a}, 32'h0);
    chk("reset fcnt_a", {24'd0, fcnt_a}, 32'h0);
    chk("reset pgood_b", pgood_b, 32'h0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      wr(1'b0, tbl[i].addr, tbl[i].data);
      idle(tbl[i].idle);
      chk($sformatf("v%0d pgood", i), pgood_a, tbl[i].pgood);
      chk($sformatf("v%0d warn", i), {31'd0, warn_a}, {31'd0, tbl[i].warn});
      chk($sformatf("v%0d fault", i), {31'd0, fault_a}, {31'd0, tbl[i].fault});
      chk($sformatf("v%0d eoc", i), {31'd0, eoc_a}, {31'd0, tbl[i].eoc});
    end
    chk("fcnt after table", {24'd0, fcnt_a}, 32'(fcnt_exp_three));

    // Saturation of the fault event counter, then clear via bit7.
    wr(1'b0, 3'd5, 8'h02);
    for (int k = 0; k < 300; k++) begin
      wr(1'b0, 3'd4, 8'h02);
      wr(1'b0, 3'd5, 8'h02);
    end
    chk("fcnt saturate", {24'd0, fcnt_a}, 32'(fcnt_exp_sat));
    wr(1'b0, 3'd5, 8'h80);
    chk("fcnt clear", {24'd0, fcnt_a}, 32'h0);

    // Aggregate mode with 12 channels.
    wr(1'b1, 3'd0, 8'hFF);
    wr(1'b1, 3'd1, 8'h0F);
    idle(3);
    chk("agg partial", pgood_b, 32'h0);
    idle(1);
    chk("agg all good", pgood_b, 32'h1);
    wr(1'b1, 3'd1, 8'hFF);
    idle(5);
    chk("agg upper discarded", pgood_b, 32'h1);
    wr(1'b1, 3'd1, 8'h07);
    idle(3);
    chk("agg before drop", pgood_b, 32'h1);
    idle(1);
    chk("agg dropped", pgood_b, 32'h0);
    chk("agg brownout fault", {31'd0, fault_b}, 32'h1);

    // Asynchronous reset in the middle of a filter count.
    wr(1'b0, 3'd4, 8'h03);
    wr(1'b0, 3'd0, 8'h00);
    idle(2);
    chk("pre-reset pgood", pgood_a, 32'hFF);
    reset_n = 1'b0;
    #1;
    chk("async pgood_a", pgood_a, 32'h0);
    chk("async flags_a", {29'd0, warn_a, fault_a, eoc_a}, 32'h0);
    chk("async fcnt_a", {24'd0, fcnt_a}, 32'h0);
    chk("async b", {pgood_b[0], fault_b}, 2'b00);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    chk("release eoc/fault", {30'd0, eoc_a, fault_a}, 32'h0);
    wr(1'b0, 3'd0, 8'hFF);
    idle(3);
    chk("restart 3 clocks", pgood_a, 32'h0);
    idle(1);
    chk("restart 4 clocks", pgood_a, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
